// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    FAULT
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_BASE_PC = 32'h8000_0000;
  localparam int          INST_W          = 32;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // I-type immediate: inst[31:20] sign-extended to a full word
  function automatic logic [31:0] sext_imm_i(input logic [INST_W-1:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetched-instruction output channel with decoded fields
interface inst_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  import ifu_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INST_W-1:0]     out_inst;
  logic                  out_fault;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [6:0]            funct7;
  logic [31:0]           imm_i;

  modport master (
    output out_valid, out_pc, out_inst, out_fault,
    output opcode, rd, funct3, rs1, rs2, funct7, imm_i,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_inst, out_fault,
    input  opcode, rd, funct3, rs1, rs2, funct7, imm_i,
    output out_ready
  );

endinterface

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - instruction store, synchronous write, synchronous read-first
module inst_rom
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [INST_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  // write and read share one edge; the non-blocking read sees the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch FSM with ROM and decoded outputs
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter  int                    ADDR_WIDTH = 32,
  parameter  int                    DEPTH      = 1024,
  parameter  logic [ADDR_WIDTH-1:0] BASE_PC    = ADDR_WIDTH'(DEFAULT_BASE_PC),
  localparam int                    IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_idx,
  input  logic [INST_W-1:0]     ld_data,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  inst_fetch_unit_if.master     fetch
);

  ifu_state_e            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  pc_ok;
  logic                  rom_re;
  logic                  valid_q;
  logic                  fault_q;
  logic [INST_W-1:0]     rom_rdata;

  // a wrapped PC lands below BASE_PC, so it faults instead of aliasing into the ROM
  assign pc_off   = pc - BASE_PC;
  assign word_off = pc_off >> 2;
  assign pc_ok    = (pc[1:0] == 2'b00) && (pc >= BASE_PC) &&
                    (word_off < ADDR_WIDTH'(DEPTH));

  // the ROM is only read for a legal PC, and not when the fetch is about to be discarded
  assign rom_re = (state == FETCH) && pc_ok && !rst && !redir_valid;

  inst_rom #(
    .DEPTH(DEPTH)
  ) u_rom (
    .clk  (clk),
    .we   (ld_en),
    .widx (ld_idx),
    .wdata(ld_data),
    .re   (rom_re),
    .ridx (word_off[IDX_W-1:0]),
    .rdata(rom_rdata)
  );

  // fetch sequencing; reset beats redirect, redirect beats the consumer handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= BASE_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (redir_valid) begin
      state   <= FETCH;
      pc      <= redir_pc;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          state   <= pc_ok ? VALID : FAULT;
          valid_q <= 1'b1;
          fault_q <= !pc_ok;
        end
        VALID: begin
          if (fetch.out_ready) begin
            state   <= FETCH;
            pc      <= pc + ADDR_WIDTH'(4);
            valid_q <= 1'b0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // pc only moves when nothing is presented, so it doubles as the presented PC
  assign fetch.out_valid = valid_q;
  assign fetch.out_fault = fault_q;
  assign fetch.out_pc    = pc;
  assign fetch.out_inst  = (valid_q && !fault_q) ? rom_rdata : '0;

  assign fetch.opcode = fetch.out_inst[6:0];
  assign fetch.rd     = fetch.out_inst[11:7];
  assign fetch.funct3 = fetch.out_inst[14:12];
  assign fetch.rs1    = fetch.out_inst[19:15];
  assign fetch.rs2    = fetch.out_inst[24:20];
  assign fetch.funct7 = fetch.out_inst[31:25];
  assign fetch.imm_i  = sext_imm_i(fetch.out_inst);

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PC and address width.
REQ-002 Parameter DEPTH, default 1024, instruction words in ROM; power of two, >=2.
REQ-003 Parameter BASE_PC, default 32'h8000_0000, reset PC and address of ROM word 0.
REQ-004 Port list: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-005 ld_en  in  1  ROM write strobe; ld_idx  in  log2(DEPTH)  word index; ld_data  in  32  word to write.
REQ-006 redir_valid  in  1  redirect request; redir_pc  in  ADDR_WIDTH  redirect target.
REQ-007 out_valid  out  1  fetched result valid; out_ready  in  1  consumer accepts.
REQ-008 out_pc  out  ADDR_WIDTH; out_inst  out  32; out_fault  out  1  misaligned/out-of-range PC.
REQ-009 Decoded outputs from out_inst: opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7, imm_i 32 (inst[31:20] sign-extended).

Function
REQ-010 Internal PC register; word index = (pc - BASE_PC) >> 2.
REQ-011 PC in range iff pc >= BASE_PC and index < DEPTH; aligned iff pc[1:0] == 0.
REQ-012 FSM states IDLE, FETCH, VALID, FAULT; reset state IDLE.
REQ-013 IDLE: out_valid=0; unconditionally to FETCH next cycle.
REQ-014 FETCH, PC aligned and in range: issue ROM read; next state VALID; out_inst = ROM data, out_fault=0.
REQ-015 FETCH, PC misaligned or out of range: no ROM read; next state FAULT; out_inst = 0, out_fault=1.
REQ-016 VALID/FAULT: out_valid=1; out_pc, out_inst, out_fault, decoded fields stable until accepted.
REQ-017 VALID with out_ready=1: pc <= pc+4; next state FETCH; throughput one instruction per 2 cycles.
REQ-018 FAULT: ignores out_ready; held until redir_valid or rst.
REQ-019 redir_valid=1 in any state: pc <= redir_pc; next state FETCH; out_valid=0 next cycle; pending output discarded, never presented.
REQ-020 redir_valid and out_ready in same cycle: redirect wins, accepted instruction counts as consumed, pc = redir_pc.
REQ-021 PC arithmetic modulo 2^ADDR_WIDTH; wrap produces out-of-range fault, never a ROM alias.
REQ-022 ROM: synchronous write on ld_en, synchronous read, 1-cycle latency.
REQ-023 Read and write same index same cycle: read returns old word (read-first).
REQ-024 ld_en legal in every state; does not stall the FSM.
REQ-025 Decoded fields driven combinationally from registered out_inst.

Reset
REQ-026 rst=1 at a clock edge: pc <= BASE_PC, state <= IDLE; overrides redirect and handshake.
REQ-027 Output reset values: out_valid=0, out_pc=BASE_PC, out_inst=0, out_fault=0.
REQ-028 ROM contents not cleared by rst; reset mid-VALID drops the presented instruction.

Structure
REQ-029 Shared package ifu_pkg: FSM state enum, default BASE_PC, INST_W=32, NOP_INST=32'h0000_0013, RV32I opcode constants.
REQ-030 One sub-module inst_rom (DEPTH x 32, sync write, sync read-first); all other logic in inst_fetch_unit.

Verification
REQ-031 Load words 0..2 = 0x00100093, 0x00200113, 0xFFF00193; out_ready=1 -> pc 0x80000000/04/08 in order, rs1=0, rd=1/2/3; imm_i third = 0xFFFFFFFF.
REQ-032 out_ready=0 for 5 cycles in VALID -> out_valid=1, out_pc/out_inst unchanged; then ready=1 -> next pc +4.
REQ-033 redir_pc=0x80000002 -> out_valid=1, out_fault=1, out_inst=0; out_ready ignored; redir_pc=0x80000000 clears fault.
REQ-034 DEPTH=4, run from BASE_PC without redirect -> pc 0x80000010 presented with out_fault=1.
REQ-035 redir_valid and out_ready same cycle in VALID, redir_pc=0x80000008 -> next presented out_pc=0x80000008, no 0x80000004.
REQ-036 rst asserted in VALID -> next cycle out_valid=0, out_pc=0x80000000; first post-reset fetch returns word 0 with contents preserved.
